// File: rtl/clock_time_sequencer.sv
// Timekeeping and alarm core for the 12-hour clock: queues the 1 Hz tick and
// button pulses, serves one per cycle in fixed priority, and runs the alarm FSM.
module clock_time_sequencer #(
    parameter int unsigned ALARM_MIN_STEP = 10,
    parameter int unsigned RING_SECONDS   = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       sec_adj,
    input  logic       min_adj,
    input  logic       hrs_adj,
    input  logic       al_adj,
    input  logic       al_toggle,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [3:0] hours,
    output logic [5:0] al_minutes,
    output logic [3:0] al_hours,
    output logic       al_on,
    output logic       alarm,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2
    } alarm_state_e;

    logic [5:0]   req;
    logic [5:0]   grant;
    logic [5:0]   pend_q, pend_d;
    logic         overrun_q, overrun_d;
    logic [5:0]   seconds_q, seconds_d;
    logic [5:0]   minutes_q, minutes_d;
    logic [3:0]   hours_q, hours_d;
    logic [5:0]   al_minutes_q, al_minutes_d;
    logic [3:0]   al_hours_q, al_hours_d;
    logic [7:0]   ring_cnt_q, ring_cnt_d;
    alarm_state_e state_q, state_d;
    logic [6:0]   al_sum;
    logic         tick_match;

    function automatic logic [5:0] inc_mod60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [3:0] inc_mod12(input logic [3:0] v);
        return (v == 4'd11) ? 4'd0 : v + 4'd1;
    endfunction

    // Bit 0 is the highest priority; the grant is the lowest set pending bit.
    assign req = {al_toggle, al_adj, hrs_adj, min_adj, sec_adj, sec_tick};

    always_comb begin
        grant     = pend_q & (~pend_q + 6'd1);
        pend_d    = (pend_q & ~grant) | req;
        overrun_d = |(req & pend_q & ~grant);
    end

    always_comb begin
        seconds_d    = seconds_q;
        minutes_d    = minutes_q;
        hours_d      = hours_q;
        al_minutes_d = al_minutes_q;
        al_hours_d   = al_hours_q;
        ring_cnt_d   = ring_cnt_q;
        state_d      = state_q;
        tick_match   = 1'b0;
        al_sum       = {1'b0, al_minutes_q} + 7'(ALARM_MIN_STEP);

        if (grant[0]) begin
            seconds_d = inc_mod60(seconds_q);
            if (seconds_q == 6'd59) begin
                minutes_d = inc_mod60(minutes_q);
                if (minutes_q == 6'd59) begin
                    hours_d = inc_mod12(hours_q);
                end
            end
            tick_match = (seconds_q == 6'd59) && (minutes_d == al_minutes_q)
                         && (hours_d == al_hours_q);
            case (state_q)
                ARMED: begin
                    if (tick_match) begin
                        state_d    = RINGING;
                        ring_cnt_d = 8'd0;
                    end
                end
                RINGING: begin
                    if (ring_cnt_q == 8'(RING_SECONDS - 1)) begin
                        state_d    = ARMED;
                        ring_cnt_d = 8'd0;
                    end else begin
                        ring_cnt_d = ring_cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end else if (grant[1]) begin
            seconds_d = inc_mod60(seconds_q);
        end else if (grant[2]) begin
            minutes_d = inc_mod60(minutes_q);
        end else if (grant[3]) begin
            hours_d = inc_mod12(hours_q);
        end else if (grant[4]) begin
            if (al_sum >= 7'd60) begin
                al_minutes_d = 6'(al_sum - 7'd60);
                al_hours_d   = inc_mod12(al_hours_q);
            end else begin
                al_minutes_d = al_sum[5:0];
            end
        end else if (grant[5]) begin
            case (state_q)
                IDLE:    state_d = ARMED;
                ARMED:   state_d = IDLE;
                default: begin
                    state_d    = IDLE;
                    ring_cnt_d = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q       <= 6'd0;
            overrun_q    <= 1'b0;
            seconds_q    <= 6'd0;
            minutes_q    <= 6'd0;
            hours_q      <= 4'd0;
            al_minutes_q <= 6'd0;
            al_hours_q   <= 4'd0;
            ring_cnt_q   <= 8'd0;
            state_q      <= IDLE;
        end else begin
            pend_q       <= pend_d;
            overrun_q    <= overrun_d;
            seconds_q    <= seconds_d;
            minutes_q    <= minutes_d;
            hours_q      <= hours_d;
            al_minutes_q <= al_minutes_d;
            al_hours_q   <= al_hours_d;
            ring_cnt_q   <= ring_cnt_d;
            state_q      <= state_d;
        end
    end

    assign seconds    = seconds_q;
    assign minutes    = minutes_q;
    assign hours      = hours_q;
    assign al_minutes = al_minutes_q;
    assign al_hours   = al_hours_q;
    assign al_on      = (state_q != IDLE);
    assign alarm      = (state_q == RINGING);
    assign busy       = |pend_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/clock_time_sequencer.md
Name: clock_time_sequencer

Overview:
- Owns the clock's timekeeping registers (time and alarm time) and the alarm state.
- Replaces ad-hoc priority chains with one arbiter that queues one-cycle update requests: the 1 Hz tick and the five debounced button pulses.
- Serves at most one request per cycle, in a fixed priority order, and never loses a request that is already pending.
- All carries are resolved in the same update, so the time outputs always hold in-range values and feed the renderer directly.

Parameters:
- ALARM_MIN_STEP, 10, minutes added to the alarm time per al_adj request (legal range 1..59).
- RING_SECONDS, 60, serviced seconds ticks spent in RINGING before the alarm auto-stops (legal range 1..255).

Ports:
- clk  in  1  system clock (31.5 MHz)
- reset  in  1  synchronous, active-high
- sec_tick  in  1  one-cycle 1 Hz pulse from the divider
- sec_adj  in  1  one-cycle debounced pulse: seconds +1
- min_adj  in  1  one-cycle debounced pulse: minutes +1
- hrs_adj  in  1  one-cycle debounced pulse: hours +1
- al_adj  in  1  one-cycle debounced pulse: alarm time +ALARM_MIN_STEP minutes
- al_toggle  in  1  one-cycle debounced pulse: alarm enable toggle
- seconds  out  6  0..59
- minutes  out  6  0..59
- hours  out  4  0..11
- al_minutes  out  6  0..59
- al_hours  out  4  0..11
- al_on  out  1  alarm enabled (state is ARMED or RINGING)
- alarm  out  1  state is RINGING; gates the buzzer
- busy  out  1  any pending flag set
- overrun  out  1  one-cycle pulse: a request arrived while its pending flag was already set, and was dropped

Behaviour:
- Reset: every output 0, every pending flag 0, ring counter 0, state IDLE. Reset overrides everything; pending requests are discarded.
- Pending flags (six, one per input):
  - A flag is set at the clock edge that samples its pulse high.
  - It is cleared at the edge that services it.
  - If a new pulse arrives on the same edge that services that flag, the flag stays set, so the request is not lost.
  - If a pulse arrives while its flag is set and not being serviced, the pulse is dropped and overrun=1 for the next cycle.
- Arbitration:
  - Each cycle, the highest-priority set flag is serviced.
  - Priority order: sec_tick > sec_adj > min_adj > hrs_adj > al_adj > al_toggle.
  - Latency: pulse in cycle N, flag set at the end of N, earliest service in N+1, outputs updated at the end of N+1 (2 clocks).
  - Worst case: all six requests drain within 7 cycles.
- Service rules (all with modulo wrap):
  - sec_tick: seconds+1. On 59->0, minutes+1. On 59->0, hours+1. Hours wrap 11->0. All carries apply in a single update.
  - sec_adj: seconds+1, 59->0, no carry.
  - min_adj: minutes+1, 59->0, no carry.
  - hrs_adj: hours+1, 11->0.
  - al_adj: compute sum = al_minutes + ALARM_MIN_STEP in 7 bits. If sum >= 60, al_minutes = sum-60 and al_hours+1 (11->0); otherwise al_minutes = sum.
  - al_toggle: IDLE->ARMED. ARMED->IDLE. RINGING->IDLE, with alarm cleared and the ring counter cleared.
- Alarm FSM (states IDLE, ARMED, RINGING):
  - ARMED->RINGING only on a sec_tick service whose new value satisfies seconds==0, minutes==al_minutes and hours==al_hours. Manual adjusts never trigger.
  - Entering RINGING loads the ring counter with 0.
  - In RINGING, each serviced sec_tick increments the ring counter. When it reaches RING_SECONDS, the state returns to ARMED and the counter clears.
  - A match tick that occurs while already RINGING is ignored.
  - Changing the alarm time during RINGING does not stop it.
- Outputs are registered with no combinational path from inputs to outputs. busy reflects the pending flags registered at the current edge.

Test Plan:
- Time 11:59:59, one sec_tick -> after 2 clocks the outputs read 00:00:00 and busy returns to 0.
- Pulse all six inputs in the same cycle from 00:00:00 with alarm IDLE -> services run on six consecutive cycles in priority order; final state 01:01:02, alarm 00:10, al_on=1, overrun never asserted.
- Set al_minutes=50, al_hours=11, then pulse al_adj -> alarm reads 00:00. Then pulse sec_adj twice, 2 cycles apart, while sec_tick is pending each time -> both sec_adj requests are applied and no overrun occurs.
- Alarm armed at 07:30, time 07:29:59, sec_tick -> alarm=1 at 07:30:00. After RING_SECONDS (60) more ticks -> alarm=0, al_on=1. A further full 12-hour cycle re-triggers it at 07:30:00.
- While RINGING, pulse al_toggle -> alarm=0 and al_on=0 within 2 clocks. Pulse sec_adj twice on consecutive cycles while the sec_adj flag is blocked behind sec_tick -> overrun pulses once and seconds advances by 1 from the adjusts.
- Assert reset with three requests pending and the alarm RINGING -> all outputs 0 the cycle after reset, and no deferred update occurs after reset is released.
